// File: rtl/tag_rx_symb_accum.sv
// Integrate-and-dump of de-spread baseband I/Q: sums NSAMP_PER_SYMB valid samples
// per symbol for NSYMB symbols after an rx_trig falling edge, one AXI-stream beat per symbol.
module tag_rx_symb_accum #(
  parameter int DATA_WIDTH     = 16,
  parameter int NSAMP_PER_SYMB = 4096,
  parameter int NSYMB          = 64,
  parameter int ACC_WIDTH      = 28
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   rx_trig,
  input  logic                   rx_valid,
  input  logic [DATA_WIDTH-1:0]  i_in,
  input  logic [DATA_WIDTH-1:0]  q_in,
  output logic [2*ACC_WIDTH-1:0] o_tdata,
  output logic                   o_tvalid,
  input  logic                   o_tready,
  output logic                   o_tlast,
  output logic [15:0]            o_symb_idx,
  output logic                   busy,
  output logic                   overflow
);

  localparam int CNT_W = $clog2(NSAMP_PER_SYMB);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t                       state, state_nxt;
  logic                         trig_d, fall, dump, last_samp, last_symb;
  logic [CNT_W-1:0]             samp_cnt;
  logic [15:0]                  symb_idx;
  logic signed [ACC_WIDTH-1:0]  acc_i, acc_q, i_ext, q_ext, sum_i, sum_q;

  assign fall      = trig_d & ~rx_trig;
  assign i_ext     = ACC_WIDTH'(signed'(i_in));
  assign q_ext     = ACC_WIDTH'(signed'(q_in));
  assign sum_i     = acc_i + i_ext;
  assign sum_q     = acc_q + q_ext;
  assign last_samp = (samp_cnt == CNT_W'(NSAMP_PER_SYMB - 1));
  assign last_symb = (symb_idx == 16'(NSYMB - 1));

  always_ff @(posedge clk) begin
    if (reset || clear) state <= IDLE;
    else                state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fall) state_nxt = ACCUM;
      ACCUM:   if (!fall && dump && last_symb) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A fall always wins over a dump: the coinciding result is discarded.
  always_comb begin
    busy = (state == ACCUM);
    dump = (state == ACCUM) && !fall && rx_valid && last_samp;
  end

  // The fall-cycle sample, if valid, becomes sample 0 of the (re)started frame.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      trig_d   <= 1'b0;
      acc_i    <= '0;
      acc_q    <= '0;
      samp_cnt <= '0;
      symb_idx <= '0;
    end else begin
      trig_d <= rx_trig;
      if (fall) begin
        acc_i    <= rx_valid ? i_ext : '0;
        acc_q    <= rx_valid ? q_ext : '0;
        samp_cnt <= rx_valid ? CNT_W'(1) : '0;
        symb_idx <= '0;
      end else if (state == ACCUM && rx_valid) begin
        if (last_samp) begin
          acc_i    <= '0;
          acc_q    <= '0;
          samp_cnt <= '0;
          symb_idx <= symb_idx + 16'd1;
        end else begin
          acc_i    <= sum_i;
          acc_q    <= sum_q;
          samp_cnt <= samp_cnt + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      o_tvalid   <= 1'b0;
      o_tdata    <= '0;
      o_tlast    <= 1'b0;
      o_symb_idx <= '0;
      overflow   <= 1'b0;
    end else if (clear) begin
      o_tvalid   <= 1'b0;
      o_tdata    <= '0;
      o_tlast    <= 1'b0;
      o_symb_idx <= '0;
    end else if (dump) begin
      if (!o_tvalid || o_tready) begin
        o_tvalid   <= 1'b1;
        o_tdata    <= {sum_i, sum_q};
        o_tlast    <= last_symb;
        o_symb_idx <= symb_idx;
      end else begin
        overflow <= 1'b1;
      end
    end else if (o_tvalid && o_tready) begin
      o_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tag_rx_symb_accum.sv
// Randomized bench for tag_rx_symb_accum against a queue-based frame/symbol model.
module tb_tag_rx_symb_accum;

  localparam int DW = 16;
  localparam int NS = 8;
  localparam int NY = 3;
  localparam int AW = 19;

  logic          clk = 1'b0;
  logic          reset, clear, rx_trig, rx_valid, o_tready;
  logic [DW-1:0] i_in, q_in;
  logic [2*AW-1:0] o_tdata;
  logic          o_tvalid, o_tlast, busy, overflow;
  logic [15:0]   o_symb_idx;

  tag_rx_symb_accum #(
    .DATA_WIDTH(DW), .NSAMP_PER_SYMB(NS), .NSYMB(NY), .ACC_WIDTH(AW)
  ) dut (
    .clk(clk), .reset(reset), .clear(clear), .rx_trig(rx_trig), .rx_valid(rx_valid),
    .i_in(i_in), .q_in(q_in), .o_tdata(o_tdata), .o_tvalid(o_tvalid), .o_tready(o_tready),
    .o_tlast(o_tlast), .o_symb_idx(o_symb_idx), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  logic        m_trig_d, m_active, m_tv, m_last, m_ovf;
  int          m_qi[$], m_qq[$];
  int          m_idx, m_bidx;
  logic [63:0] m_data;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset(input logic keep_ovf);
    m_trig_d = 0; m_active = 0; m_tv = 0; m_last = 0; m_data = '0;
    m_idx = 0; m_bidx = 0; m_qi.delete(); m_qq.delete();
    if (!keep_ovf) m_ovf = 0;
  endtask

  task automatic model_step();
    logic        fall, beat, b_last;
    int          b_idx;
    longint      si, sq;
    logic [AW-1:0] ti, tq;
    if (reset) begin model_reset(0); return; end
    if (clear) begin model_reset(1); return; end
    fall = m_trig_d && !rx_trig;
    beat = 0; b_idx = 0; b_last = 0; ti = '0; tq = '0;
    if (fall) begin
      m_active = 1; m_idx = 0; m_qi.delete(); m_qq.delete();
      if (rx_valid) begin m_qi.push_back(int'($signed(i_in))); m_qq.push_back(int'($signed(q_in))); end
    end else if (m_active && rx_valid) begin
      m_qi.push_back(int'($signed(i_in))); m_qq.push_back(int'($signed(q_in)));
      if (m_qi.size() == NS) begin
        si = 0; sq = 0;
        foreach (m_qi[k]) begin si += m_qi[k]; sq += m_qq[k]; end
        ti = si[AW-1:0]; tq = sq[AW-1:0];
        beat = 1; b_idx = m_idx; b_last = (m_idx == NY - 1);
        m_qi.delete(); m_qq.delete();
        m_idx++;
        if (b_last) m_active = 0;
      end
    end
    if (beat) begin
      if (!m_tv || o_tready) begin
        m_tv = 1; m_data = 64'({ti, tq}); m_bidx = b_idx; m_last = b_last;
      end else m_ovf = 1;
    end else if (m_tv && o_tready) m_tv = 0;
    m_trig_d = rx_trig;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("tvalid", 64'(o_tvalid), 64'(m_tv));
    check("busy", 64'(busy), 64'(m_active));
    check("overflow", 64'(overflow), 64'(m_ovf));
    if (m_tv) begin
      check("tdata", 64'(o_tdata), m_data);
      check("tlast", 64'(o_tlast), 64'(m_last));
      check("symb_idx", 64'(o_symb_idx), 64'(m_bidx));
    end
  endtask

  function automatic logic [DW-1:0] pick_sample(input int mode);
    case (mode)
      1:       return 16'h7FFF;
      2:       return 16'h8000;
      default: return DW'($urandom);
    endcase
  endfunction

  initial begin
    int mode, trig_rate, valid_pct, ready_pct;
    reset = 1; clear = 0; rx_trig = 0; rx_valid = 0; o_tready = 0; i_in = '0; q_in = '0;
    m_ovf = 0; model_reset(0);
    cycle(); cycle();
    check("rst_tdata", 64'(o_tdata), 64'd0);
    check("rst_tlast", 64'(o_tlast), 64'd0);
    check("rst_idx", 64'(o_symb_idx), 64'd0);
    reset = 0;
    for (int phase = 0; phase < 8; phase++) begin
      mode      = phase % 4;
      trig_rate = (phase < 4) ? 90 : 25;
      valid_pct = (phase % 2) ? 50 : 100;
      ready_pct = (phase == 2 || phase == 6) ? 20 : ((phase == 0) ? 100 : 70);
      for (int c = 0; c < 500; c++) begin
        if (rx_trig) rx_trig = ($urandom_range(2, 0) != 0);
        else         rx_trig = ($urandom_range(trig_rate - 1, 0) == 0);
        rx_valid = ($urandom_range(99, 0) < valid_pct);
        o_tready = ($urandom_range(99, 0) < ready_pct);
        clear    = ($urandom_range(399, 0) == 0);
        if (mode == 3) begin i_in = 16'h7FFF; q_in = 16'h8000; end
        else begin i_in = pick_sample(int'($urandom_range(3, 0))); q_in = pick_sample(int'($urandom_range(3, 0))); end
        cycle();
      end
      clear = 0;
      if (phase == 3) begin
        reset = 1; cycle(); reset = 0;
        check("ovf_after_reset", 64'(overflow), 64'd0);
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
